// File: rtl/semaforo_multivias.sv
// semaforo_multivias -- N-approach traffic-light controller, one per intersection.
//
// Serves the approaches round-robin: green, yellow, all-red clearance, then the
// next approach goes green. A pedestrian request shortens the current green once
// the minimum green has elapsed. Night mode flashes every yellow. All phase
// timing is counted in ticks produced by an internal prescaler.
//
// Ports:
//   clk           in   1        system clock
//   reset_n       in   1        synchronous reset, active-low
//   ped_req       in   1        pedestrian request pulse, synchronous to clk
//   modo_noturno  in   1        level; 1 = night flashing mode
//   led_verde     out  N_VIAS   green per approach, active-low
//   led_amarelo   out  N_VIAS   yellow per approach, active-low
//   led_vermelho  out  N_VIAS   red per approach, active-low
//   via_atual     out  W_IDX    index of the approach currently served
//   ped_pend      out  1        pedestrian request latched, not yet served
module semaforo_multivias #(
  parameter int unsigned CLK_FREQ     = 27000000,
  parameter int unsigned TICK_DIV     = 27000000,
  parameter int unsigned N_VIAS       = 2,
  parameter int unsigned VERDE_TIME   = 10,
  parameter int unsigned MIN_VERDE    = 4,
  parameter int unsigned AMARELO_TIME = 3,
  parameter int unsigned LIMPEZA_TIME = 2,
  localparam int unsigned W_IDX       = $clog2(N_VIAS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ped_req,
  input  logic              modo_noturno,
  output logic [N_VIAS-1:0] led_verde,
  output logic [N_VIAS-1:0] led_amarelo,
  output logic [N_VIAS-1:0] led_vermelho,
  output logic [W_IDX-1:0]  via_atual,
  output logic              ped_pend
);

  localparam int unsigned W_P    = $clog2(TICK_DIV);
  localparam int unsigned MAX_AV = (VERDE_TIME > AMARELO_TIME) ? VERDE_TIME : AMARELO_TIME;
  localparam int unsigned MAX_T  = (MAX_AV > LIMPEZA_TIME) ? MAX_AV : LIMPEZA_TIME;
  localparam int unsigned W_T    = $clog2(MAX_T + 1);

  // Reject parameter sets the timing logic cannot represent.
  if (CLK_FREQ == 0 || TICK_DIV < 2 || N_VIAS < 2 || N_VIAS > 8 || VERDE_TIME < 1 ||
      MIN_VERDE < 1 || MIN_VERDE > VERDE_TIME || AMARELO_TIME < 1 || LIMPEZA_TIME < 1) begin : g_bad_param
    $error("semaforo_multivias: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_VERDE   = 2'd0,
    S_AMARELO = 2'd1,
    S_LIMPEZA = 2'd2,
    S_NOTURNO = 2'd3
  } estado_t;

  estado_t          estado_r, estado_nx_s;
  logic [W_P-1:0]   presc_r;
  logic [W_T-1:0]   timer_r;
  logic [W_IDX-1:0] via_r, via_nx_s;
  logic             ped_r, ped_nx_s;
  logic             pisca_r, pisca_nx_s;
  logic             tick_s;
  logic [N_VIAS-1:0] sel_s;

  assign tick_s = (presc_r == W_P'(TICK_DIV - 1));

  // State, timing and request registers; reset abandons any phase in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_r  <= '0;
      timer_r  <= '0;
      estado_r <= S_LIMPEZA;
      via_r    <= W_IDX'(N_VIAS - 1);
      ped_r    <= 1'b0;
      pisca_r  <= 1'b0;
    end else begin
      presc_r  <= tick_s ? '0 : presc_r + W_P'(1);
      // Every state change restarts phase timing from zero.
      if (estado_nx_s != estado_r) begin
        timer_r <= '0;
      end else if (tick_s) begin
        timer_r <= timer_r + W_T'(1);
      end else begin
        timer_r <= timer_r;
      end
      estado_r <= estado_nx_s;
      via_r    <= via_nx_s;
      ped_r    <= ped_nx_s;
      pisca_r  <= pisca_nx_s;
    end
  end

  // Next-state logic: night mode is checked every cycle, phase changes only on a tick.
  always_comb begin
    estado_nx_s = estado_r;
    via_nx_s    = via_r;
    ped_nx_s    = ped_r;
    pisca_nx_s  = pisca_r;
    if (estado_r == S_NOTURNO) begin
      if (!modo_noturno) begin
        // Parking on the last index makes approach 0 the first one served.
        estado_nx_s = S_LIMPEZA;
        via_nx_s    = W_IDX'(N_VIAS - 1);
      end else if (tick_s) begin
        pisca_nx_s = ~pisca_r;
      end else begin
        pisca_nx_s = pisca_r;
      end
    end else if (modo_noturno) begin
      estado_nx_s = S_NOTURNO;
      pisca_nx_s  = 1'b0;
      ped_nx_s    = 1'b0;
    end else begin
      case (estado_r)
        S_VERDE: begin
          if (ped_req) begin
            ped_nx_s = 1'b1;
          end else begin
            ped_nx_s = ped_r;
          end
          // Leaving green serves the request, including one arriving this same cycle.
          if (tick_s && ((timer_r == W_T'(VERDE_TIME - 1)) ||
                         (ped_r && (timer_r >= W_T'(MIN_VERDE - 1))))) begin
            estado_nx_s = S_AMARELO;
            ped_nx_s    = 1'b0;
          end else begin
            estado_nx_s = S_VERDE;
          end
        end
        S_AMARELO: begin
          if (tick_s && (timer_r == W_T'(AMARELO_TIME - 1))) begin
            estado_nx_s = S_LIMPEZA;
          end else begin
            estado_nx_s = S_AMARELO;
          end
        end
        S_LIMPEZA: begin
          if (tick_s && (timer_r == W_T'(LIMPEZA_TIME - 1))) begin
            estado_nx_s = S_VERDE;
            // Explicit wrap so non-power-of-2 approach counts work.
            if (via_r == W_IDX'(N_VIAS - 1)) begin
              via_nx_s = '0;
            end else begin
              via_nx_s = via_r + W_IDX'(1);
            end
          end else begin
            estado_nx_s = S_LIMPEZA;
          end
        end
        default: begin
          estado_nx_s = S_LIMPEZA;
        end
      endcase
    end
  end

  assign sel_s = {{(N_VIAS - 1){1'b0}}, 1'b1} << via_r;

  // LED decode (active-low): the served approach shows its colour, all others red.
  always_comb begin
    led_verde    = {N_VIAS{1'b1}};
    led_amarelo  = {N_VIAS{1'b1}};
    led_vermelho = {N_VIAS{1'b1}};
    case (estado_r)
      S_VERDE: begin
        led_verde    = ~sel_s;
        led_vermelho = sel_s;
      end
      S_AMARELO: begin
        led_amarelo  = ~sel_s;
        led_vermelho = sel_s;
      end
      S_LIMPEZA: begin
        led_vermelho = {N_VIAS{1'b0}};
      end
      S_NOTURNO: begin
        // Yellow lit while pisca is low.
        led_amarelo = {N_VIAS{pisca_r}};
      end
      default: begin
        led_vermelho = {N_VIAS{1'b0}};
      end
    endcase
  end

  assign via_atual = via_r;
  assign ped_pend  = ped_r;

endmodule

// File: tb/tb_semaforo_multivias.sv
module tb_semaforo_multivias;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       modo_noturno = 1'b0;
  logic [2:0] led_verde, led_amarelo, led_vermelho;
  logic [1:0] via_atual;
  logic       ped_pend;
  logic [8:0] leds;

  int   total_chk = 0;
  int   bad_chk = 0;
  int   cur_cyc = 0;
  logic mon_en = 1'b0;
  logic night_tb = 1'b0;

  semaforo_multivias #(
    .CLK_FREQ(27000000), .TICK_DIV(4), .N_VIAS(3), .VERDE_TIME(5),
    .MIN_VERDE(2), .AMARELO_TIME(2), .LIMPEZA_TIME(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ped_req(ped_req), .modo_noturno(modo_noturno),
    .led_verde(led_verde), .led_amarelo(led_amarelo), .led_vermelho(led_vermelho),
    .via_atual(via_atual), .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  assign leds = {led_verde, led_amarelo, led_vermelho};

  // Expected {verde, amarelo, vermelho}: 0 all red, 1 green v, 2 yellow v, 3 night lit, 4 night dark.
  function automatic logic [8:0] pat(input int kind, input int v);
    logic [2:0] sel;
    sel = 3'b001 << v;
    case (kind)
      1:       pat = {~sel, 3'b111, sel};
      2:       pat = {3'b111, ~sel, sel};
      3:       pat = {3'b111, 3'b000, 3'b111};
      4:       pat = {3'b111, 3'b111, 3'b111};
      default: pat = {3'b111, 3'b111, 3'b000};
    endcase
  endfunction

  // Safety invariant outside night mode: one colour per approach, at most one approach not red.
  always @(negedge clk) begin
    if (mon_en && !night_tb) begin
      for (int i = 0; i < 3; i++) begin
        total_chk = total_chk + 1;
        if ($countones({led_verde[i], led_amarelo[i], led_vermelho[i]}) != 2) begin
          bad_chk = bad_chk + 1;
          $display("FAIL invariant_colour t=%0t via=%0d got=%b%b%b", $time, i,
                   led_verde[i], led_amarelo[i], led_vermelho[i]);
        end
      end
      total_chk = total_chk + 1;
      if ($countones(led_vermelho) > 1) begin
        bad_chk = bad_chk + 1;
        $display("FAIL invariant_nonred t=%0t vermelho=%b", $time, led_vermelho);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ped_req = 1'b0;
    modo_noturno = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cur_cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic goto(input int c);
    while (cur_cyc < c) begin
      @(negedge clk);
      cur_cyc = cur_cyc + 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ped_req = 1'b1;
    modo_noturno = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_chk = total_chk + 3;
    if (leds !== pat(0, 0)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL reset_leds got=%b exp=%b", leds, pat(0, 0));
    end
    if (via_atual !== 2'd2) begin
      bad_chk = bad_chk + 1;
      $display("FAIL reset_via got=%0d exp=2", via_atual);
    end
    if (ped_pend !== 1'b0) begin
      bad_chk = bad_chk + 1;
      $display("FAIL reset_ped got=%b exp=0", ped_pend);
    end
    ped_req = 1'b0;
    reset_n = 1'b1;
    cur_cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_free_run();
    int d, k, v;
    do_reset();
    for (int c = 0; c < 104; c++) begin
      goto(c);
      if (c < 4) begin
        k = 0;
        v = 2;
      end else begin
        d = c - 4;
        v = (d / 32) % 3;
        k = ((d % 32) < 20) ? 1 : (((d % 32) < 28) ? 2 : 0);
      end
      total_chk = total_chk + 3;
      if (leds !== pat(k, v)) begin
        bad_chk = bad_chk + 1;
        $display("FAIL free_run_leds c=%0d got=%b exp=%b", c, leds, pat(k, v));
      end
      if (via_atual !== 2'(v)) begin
        bad_chk = bad_chk + 1;
        $display("FAIL free_run_via c=%0d got=%0d exp=%0d", c, via_atual, v);
      end
      if (ped_pend !== 1'b0) begin
        bad_chk = bad_chk + 1;
        $display("FAIL free_run_ped c=%0d got=%b exp=0", c, ped_pend);
      end
    end
  endtask

  task automatic test_ped_cut();
    int cyc[6] = '{7, 11, 12, 19, 20, 24};
    int knd[6] = '{1, 1, 2, 2, 0, 1};
    int via[6] = '{0, 0, 0, 0, 0, 1};
    logic pp[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    goto(6);
    ped_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      goto(cyc[i]);
      ped_req = 1'b0;
      total_chk = total_chk + 3;
      if (leds !== pat(knd[i], via[i])) begin
        bad_chk = bad_chk + 1;
        $display("FAIL ped_cut_leds c=%0d got=%b exp=%b", cyc[i], leds, pat(knd[i], via[i]));
      end
      if (via_atual !== 2'(via[i])) begin
        bad_chk = bad_chk + 1;
        $display("FAIL ped_cut_via c=%0d got=%0d exp=%0d", cyc[i], via_atual, via[i]);
      end
      if (ped_pend !== pp[i]) begin
        bad_chk = bad_chk + 1;
        $display("FAIL ped_cut_pend c=%0d got=%b exp=%b", cyc[i], ped_pend, pp[i]);
      end
    end
  endtask

  task automatic test_ped_ignored();
    int cyc[4] = '{26, 34, 55, 56};
    int knd[4] = '{2, 0, 1, 2};
    int via[4] = '{0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      // Pulse a request one cycle before each of the first two checkpoints (yellow, clearance).
      if (i < 2) begin
        goto(cyc[i] - 1);
        ped_req = 1'b1;
      end
      goto(cyc[i]);
      ped_req = 1'b0;
      total_chk = total_chk + 2;
      if (leds !== pat(knd[i], via[i])) begin
        bad_chk = bad_chk + 1;
        $display("FAIL ped_ignored_leds c=%0d got=%b exp=%b", cyc[i], leds, pat(knd[i], via[i]));
      end
      if (ped_pend !== 1'b0) begin
        bad_chk = bad_chk + 1;
        $display("FAIL ped_ignored_pend c=%0d got=%b exp=0", cyc[i], ped_pend);
      end
    end
  endtask

  task automatic test_night();
    int cyc[9] = '{8, 11, 12, 14, 15, 16, 19, 20, 23};
    int knd[9] = '{3, 3, 4, 4, 4, 3, 3, 0, 0};
    do_reset();
    goto(5);
    ped_req = 1'b1;
    goto(6);
    ped_req = 1'b0;
    total_chk = total_chk + 1;
    if (ped_pend !== 1'b1) begin
      bad_chk = bad_chk + 1;
      $display("FAIL night_prelatch got=%b exp=1", ped_pend);
    end
    goto(7);
    modo_noturno = 1'b1;
    night_tb = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cyc[i] == 14) begin
        goto(13);
        ped_req = 1'b1;
      end
      goto(cyc[i]);
      ped_req = 1'b0;
      if (cyc[i] >= 20) night_tb = 1'b0;
      total_chk = total_chk + 2;
      if (leds !== pat(knd[i], 0)) begin
        bad_chk = bad_chk + 1;
        $display("FAIL night_leds c=%0d got=%b exp=%b", cyc[i], leds, pat(knd[i], 0));
      end
      if (ped_pend !== 1'b0) begin
        bad_chk = bad_chk + 1;
        $display("FAIL night_pend c=%0d got=%b exp=0", cyc[i], ped_pend);
      end
      if (cyc[i] == 19) modo_noturno = 1'b0;
      if (cyc[i] == 20) begin
        total_chk = total_chk + 1;
        if (via_atual !== 2'd2) begin
          bad_chk = bad_chk + 1;
          $display("FAIL night_exit_via got=%0d exp=2", via_atual);
        end
      end
    end
    goto(24);
    total_chk = total_chk + 2;
    if (leds !== pat(1, 0)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL night_resume_leds got=%b exp=%b", leds, pat(1, 0));
    end
    if (via_atual !== 2'd0) begin
      bad_chk = bad_chk + 1;
      $display("FAIL night_resume_via got=%0d exp=0", via_atual);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    goto(58);
    total_chk = total_chk + 1;
    if (leds !== pat(2, 1)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_pre_leds got=%b exp=%b", leds, pat(2, 1));
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cur_cyc = 0;
    total_chk = total_chk + 3;
    if (leds !== pat(0, 0)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_reset_leds got=%b exp=%b", leds, pat(0, 0));
    end
    if (via_atual !== 2'd2) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_reset_via got=%0d exp=2", via_atual);
    end
    if (ped_pend !== 1'b0) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_reset_ped got=%b exp=0", ped_pend);
    end
    goto(3);
    total_chk = total_chk + 1;
    if (leds !== pat(0, 0)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_clear_leds got=%b exp=%b", leds, pat(0, 0));
    end
    goto(4);
    total_chk = total_chk + 2;
    if (leds !== pat(1, 0)) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_green_leds got=%b exp=%b", leds, pat(1, 0));
    end
    if (via_atual !== 2'd0) begin
      bad_chk = bad_chk + 1;
      $display("FAIL mid_green_via got=%0d exp=0", via_atual);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_cut();
    test_ped_ignored();
    test_night();
    test_reset_mid();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
